// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: shares the 8-bit MAC transmit stream between the ARP reply
// source and the IP/UDP source. A grant is held from the first byte to tlast,
// short frames are zero-padded up to MIN_LEN, and an idle gap of GAP_CYCLES
// clocks follows every frame. Ties in IDLE alternate between the sources.
module eth_tx_arbiter #(
  parameter int MIN_LEN    = 60,
  parameter int GAP_CYCLES = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  arp_tdata_in,
  input  logic        arp_tvalid_in,
  input  logic        arp_tlast_in,
  output logic        arp_tready_out,
  input  logic [7:0]  ip_tdata_in,
  input  logic        ip_tvalid_in,
  input  logic        ip_tlast_in,
  output logic        ip_tready_out,
  output logic [7:0]  mac_tdata_out,
  output logic        mac_tvalid_out,
  output logic        mac_tlast_out,
  input  logic        mac_tready_in,
  output logic        busy_out,
  output logic [15:0] arp_pkt_cnt_out,
  output logic [15:0] ip_pkt_cnt_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARP,
    S_IP,
    S_PAD,
    S_GAP
  } state_t;

  localparam logic        GRANT_ARP = 1'b0;
  localparam logic        GRANT_IP  = 1'b1;
  localparam int          GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int          GAP_LAST  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [11:0] MIN_LEN_C = 12'(MIN_LEN);
  // With no gap configured the frame-ending accept returns straight to IDLE.
  localparam state_t      END_STATE = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [10:0]      byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [15:0]      arp_cnt_q, arp_cnt_d;
  logic [15:0]      ip_cnt_q, ip_cnt_d;

  logic [11:0]      byte_cnt_inc;
  logic [10:0]      byte_cnt_sat;
  logic             len_ok;
  logic             pad_last;
  logic             gap_done;
  logic [7:0]       src_tdata;
  logic             src_tvalid;
  logic             src_tlast;

  // byte_cnt+1 is evaluated one bit wider so the MIN_LEN compare never wraps.
  assign byte_cnt_inc = {1'b0, byte_cnt_q} + 12'd1;
  assign byte_cnt_sat = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_inc[10:0];
  assign len_ok       = (byte_cnt_inc >= MIN_LEN_C);
  assign pad_last     = (byte_cnt_inc == MIN_LEN_C);
  assign gap_done     = (gap_cnt_q == GAP_W'(GAP_LAST));

  assign src_tdata    = (state_q == S_IP) ? ip_tdata_in  : arp_tdata_in;
  assign src_tvalid   = (state_q == S_IP) ? ip_tvalid_in : arp_tvalid_in;
  assign src_tlast    = (state_q == S_IP) ? ip_tlast_in  : arp_tlast_in;

  assign busy_out        = (state_q != S_IDLE);
  assign arp_pkt_cnt_out = arp_cnt_q;
  assign ip_pkt_cnt_out  = ip_cnt_q;

  // State, grant history, byte/gap counters and packet counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= GRANT_IP;
      byte_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      arp_cnt_q    <= '0;
      ip_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      byte_cnt_q   <= byte_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      arp_cnt_q    <= arp_cnt_d;
      ip_cnt_q     <= ip_cnt_d;
    end
  end

  // Arbitration, pass-through muxing, padding and gap sequencing.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    byte_cnt_d     = byte_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    arp_cnt_d      = arp_cnt_q;
    ip_cnt_d       = ip_cnt_q;
    mac_tdata_out  = 8'h00;
    mac_tvalid_out = 1'b0;
    mac_tlast_out  = 1'b0;
    arp_tready_out = 1'b0;
    ip_tready_out  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // ARP wins a tie only when IP had the previous grant.
        if (arp_tvalid_in && (!ip_tvalid_in || last_grant_q == GRANT_IP)) begin
          state_d      = S_ARP;
          last_grant_d = GRANT_ARP;
          byte_cnt_d   = '0;
        end else if (ip_tvalid_in) begin
          state_d      = S_IP;
          last_grant_d = GRANT_IP;
          byte_cnt_d   = '0;
        end
      end

      S_ARP, S_IP: begin
        mac_tdata_out  = src_tdata;
        mac_tvalid_out = src_tvalid;
        mac_tlast_out  = src_tlast && len_ok;
        if (state_q == S_IP) ip_tready_out  = mac_tready_in;
        else                 arp_tready_out = mac_tready_in;
        if (src_tvalid && mac_tready_in) begin
          byte_cnt_d = byte_cnt_sat;
          if (src_tlast) begin
            if (len_ok) begin
              state_d   = END_STATE;
              gap_cnt_d = '0;
              if (state_q == S_IP) ip_cnt_d  = ip_cnt_q + 16'd1;
              else                 arp_cnt_d = arp_cnt_q + 16'd1;
            end else begin
              state_d = S_PAD;
            end
          end
        end
      end

      S_PAD: begin
        mac_tvalid_out = 1'b1;
        mac_tlast_out  = pad_last;
        if (mac_tready_in) begin
          byte_cnt_d = byte_cnt_sat;
          if (pad_last) begin
            state_d   = END_STATE;
            gap_cnt_d = '0;
            if (last_grant_q == GRANT_IP) ip_cnt_d  = ip_cnt_q + 16'd1;
            else                          arp_cnt_d = arp_cnt_q + 16'd1;
          end
        end
      end

      S_GAP: begin
        if (gap_done) begin
          state_d   = S_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter. Instance u_a uses the default
// parameters (MIN_LEN 60, GAP 12); u_b uses GAP_CYCLES 0. Both share the
// stimulus; sel chooses which instance the source model handshakes with.
module tb_eth_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  arp_tdata, ip_tdata;
  logic        arp_tvalid, arp_tlast, ip_tvalid, ip_tlast, mac_tready;

  logic [7:0]  a_mac_tdata, b_mac_tdata;
  logic        a_mac_tvalid, b_mac_tvalid, a_mac_tlast, b_mac_tlast;
  logic        a_arp_tready, b_arp_tready, a_ip_tready, b_ip_tready;
  logic        a_busy, b_busy;
  logic [15:0] a_arp_cnt, b_arp_cnt, a_ip_cnt, b_ip_cnt;

  eth_tx_arbiter u_a (
    .clk(clk), .reset(reset),
    .arp_tdata_in(arp_tdata), .arp_tvalid_in(arp_tvalid), .arp_tlast_in(arp_tlast),
    .arp_tready_out(a_arp_tready),
    .ip_tdata_in(ip_tdata), .ip_tvalid_in(ip_tvalid), .ip_tlast_in(ip_tlast),
    .ip_tready_out(a_ip_tready),
    .mac_tdata_out(a_mac_tdata), .mac_tvalid_out(a_mac_tvalid), .mac_tlast_out(a_mac_tlast),
    .mac_tready_in(mac_tready), .busy_out(a_busy),
    .arp_pkt_cnt_out(a_arp_cnt), .ip_pkt_cnt_out(a_ip_cnt)
  );

  eth_tx_arbiter #(.MIN_LEN(60), .GAP_CYCLES(0)) u_b (
    .clk(clk), .reset(reset),
    .arp_tdata_in(arp_tdata), .arp_tvalid_in(arp_tvalid), .arp_tlast_in(arp_tlast),
    .arp_tready_out(b_arp_tready),
    .ip_tdata_in(ip_tdata), .ip_tvalid_in(ip_tvalid), .ip_tlast_in(ip_tlast),
    .ip_tready_out(b_ip_tready),
    .mac_tdata_out(b_mac_tdata), .mac_tvalid_out(b_mac_tvalid), .mac_tlast_out(b_mac_tlast),
    .mac_tready_in(mac_tready), .busy_out(b_busy),
    .arp_pkt_cnt_out(b_arp_cnt), .ip_pkt_cnt_out(b_ip_cnt)
  );

  logic        sel;
  logic [7:0]  v_mac_tdata;
  logic        v_mac_tvalid, v_mac_tlast, v_arp_tready, v_ip_tready, v_busy;
  logic [15:0] v_arp_cnt, v_ip_cnt;

  assign v_mac_tdata  = sel ? b_mac_tdata  : a_mac_tdata;
  assign v_mac_tvalid = sel ? b_mac_tvalid : a_mac_tvalid;
  assign v_mac_tlast  = sel ? b_mac_tlast  : a_mac_tlast;
  assign v_arp_tready = sel ? b_arp_tready : a_arp_tready;
  assign v_ip_tready  = sel ? b_ip_tready  : a_ip_tready;
  assign v_busy       = sel ? b_busy       : a_busy;
  assign v_arp_cnt    = sel ? b_arp_cnt    : a_arp_cnt;
  assign v_ip_cnt     = sel ? b_ip_cnt     : a_ip_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int fc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input bit is_ip, input int i);
    if (is_ip) return 8'(8'hA0 + i);
    else       return 8'(i * 3 + 1);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    arp_tvalid = 1'b0; arp_tdata = 8'h00; arp_tlast = 1'b0;
    ip_tvalid  = 1'b0; ip_tdata  = 8'h00; ip_tlast  = 1'b0;
    mac_tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      arp_tvalid = 1'b0; arp_tlast = 1'b0;
      ip_tvalid  = 1'b0; ip_tlast  = 1'b0;
      mac_tready = 1'b1;
    end
  endtask

  // Sends one frame of len bytes from the chosen source, optionally keeping the
  // other source requesting with its first byte, and checks every MAC byte.
  // first_cyc returns the loop cycle of the first valid MAC byte.
  task automatic run_frame(input bit is_ip, input int len, input bit other_pending,
                           input bit bp, input int abort_at, input string tag,
                           output int first_cyc);
    int sent, got, cyc, exp_len;
    bit done, bad_rdy;
    logic s_rdy, o_rdy, s_vld;
    sent = 0; got = 0; cyc = 0; done = 0; bad_rdy = 0; first_cyc = -1;
    exp_len = (len < 60) ? 60 : len;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      if (is_ip) begin
        ip_tvalid  = (sent < len);
        ip_tdata   = (sent < len) ? pat(1'b1, sent) : 8'h00;
        ip_tlast   = (sent == len - 1);
        arp_tvalid = other_pending;
        arp_tdata  = other_pending ? pat(1'b0, 0) : 8'h00;
        arp_tlast  = 1'b0;
      end else begin
        arp_tvalid = (sent < len);
        arp_tdata  = (sent < len) ? pat(1'b0, sent) : 8'h00;
        arp_tlast  = (sent == len - 1);
        ip_tvalid  = other_pending;
        ip_tdata   = other_pending ? pat(1'b1, 0) : 8'h00;
        ip_tlast   = 1'b0;
      end
      mac_tready = bp ? ((cyc % 2) == 0) : 1'b1;
      #1;
      s_rdy = is_ip ? v_ip_tready  : v_arp_tready;
      o_rdy = is_ip ? v_arp_tready : v_ip_tready;
      s_vld = is_ip ? ip_tvalid    : arp_tvalid;
      if (o_rdy !== 1'b0) bad_rdy = 1;
      if (v_mac_tvalid && first_cyc < 0) first_cyc = cyc;
      if (v_mac_tvalid && got < len && s_rdy !== mac_tready) bad_rdy = 1;
      if (got >= len && s_rdy !== 1'b0) bad_rdy = 1;
      if (v_mac_tvalid && mac_tready) begin
        check($sformatf("%s/data%0d", tag, got), 32'(v_mac_tdata),
              32'((got < len) ? pat(is_ip, got) : 8'h00));
        check($sformatf("%s/last%0d", tag, got), 32'(v_mac_tlast), 32'(got == exp_len - 1));
        if (v_mac_tlast) done = 1;
        got++;
      end
      if (sent < len && s_vld && s_rdy) sent++;
      cyc++;
      if (abort_at >= 0 && got == abort_at) break;
    end
    if (abort_at < 0) begin
      check({tag, "/complete"}, 32'(done), 32'd1);
      check({tag, "/bytes"}, 32'(got), 32'(exp_len));
      check({tag, "/tready"}, 32'(bad_rdy), 32'd0);
    end
  endtask

  initial begin
    sel = 1'b0;
    reset = 1'b1;
    arp_tvalid = 1'b0; arp_tdata = 8'h00; arp_tlast = 1'b0;
    ip_tvalid  = 1'b0; ip_tdata  = 8'h00; ip_tlast  = 1'b0;
    mac_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst/tvalid", 32'(v_mac_tvalid), 32'd0);
    check("rst/tdata", 32'(v_mac_tdata), 32'd0);
    check("rst/tlast", 32'(v_mac_tlast), 32'd0);
    check("rst/arp_tready", 32'(v_arp_tready), 32'd0);
    check("rst/ip_tready", 32'(v_ip_tready), 32'd0);
    check("rst/busy", 32'(v_busy), 32'd0);
    check("rst/arp_cnt", 32'(v_arp_cnt), 32'd0);
    check("rst/ip_cnt", 32'(v_ip_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // ARP-only 42-byte frame padded to 60, then a 100-byte IP frame after the gap.
    run_frame(1'b0, 42, 1'b0, 1'b0, -1, "arp42", fc);
    check("arp42/first_cyc", 32'(fc), 32'd1);
    @(posedge clk); #1;
    check("arp42/busy_gap", 32'(v_busy), 32'd1);
    check("arp42/arp_cnt", 32'(v_arp_cnt), 32'd1);
    run_frame(1'b1, 100, 1'b0, 1'b0, -1, "ip100", fc);
    check("ip100/gap_then_first", 32'(fc), 32'd13);
    @(posedge clk); #1;
    check("ip100/ip_cnt", 32'(v_ip_cnt), 32'd1);
    check("ip100/arp_cnt", 32'(v_arp_cnt), 32'd1);
    idle(20);
    check("idle/busy", 32'(v_busy), 32'd0);

    // Simultaneous requests from reset, then both continuously pending.
    do_reset();
    run_frame(1'b0, 42, 1'b1, 1'b0, -1, "alt0_arp", fc);
    run_frame(1'b1, 64, 1'b1, 1'b0, -1, "alt1_ip", fc);
    run_frame(1'b0, 60, 1'b1, 1'b0, -1, "alt2_arp60", fc);
    run_frame(1'b1, 59, 1'b0, 1'b0, -1, "alt3_ip59", fc);
    @(posedge clk); #1;
    check("alt/arp_cnt", 32'(v_arp_cnt), 32'd2);
    check("alt/ip_cnt", 32'(v_ip_cnt), 32'd2);
    idle(20);

    // Backpressure toggling during pass-through and during padding.
    do_reset();
    run_frame(1'b1, 64, 1'b0, 1'b1, -1, "ip64bp", fc);
    idle(20);
    run_frame(1'b0, 42, 1'b0, 1'b1, -1, "arp42bp", fc);
    @(posedge clk); #1;
    check("bp/arp_cnt", 32'(v_arp_cnt), 32'd1);
    check("bp/ip_cnt", 32'(v_ip_cnt), 32'd1);
    idle(20);

    // Reset in the middle of an ARP frame.
    run_frame(1'b0, 42, 1'b0, 1'b0, 20, "arp_abort", fc);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort/tvalid", 32'(v_mac_tvalid), 32'd0);
    check("abort/tdata", 32'(v_mac_tdata), 32'd0);
    check("abort/tlast", 32'(v_mac_tlast), 32'd0);
    check("abort/arp_tready", 32'(v_arp_tready), 32'd0);
    check("abort/busy", 32'(v_busy), 32'd0);
    check("abort/arp_cnt", 32'(v_arp_cnt), 32'd0);
    check("abort/ip_cnt", 32'(v_ip_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    arp_tvalid = 1'b0; arp_tlast = 1'b0;
    run_frame(1'b1, 70, 1'b0, 1'b0, -1, "ip_after_rst", fc);
    check("ip_after_rst/first_cyc", 32'(fc), 32'd1);
    @(posedge clk); #1;
    check("ip_after_rst/ip_cnt", 32'(v_ip_cnt), 32'd1);
    check("ip_after_rst/arp_cnt", 32'(v_arp_cnt), 32'd0);
    idle(20);

    // GAP_CYCLES = 0 instance: back-to-back frames and counter wrap.
    sel = 1'b1;
    do_reset();
    run_frame(1'b1, 64, 1'b0, 1'b0, -1, "b_ip0", fc);
    check("b_ip0/first_cyc", 32'(fc), 32'd1);
    run_frame(1'b1, 64, 1'b0, 1'b0, -1, "b_ip1", fc);
    check("b_ip1/one_idle", 32'(fc), 32'd1);
    @(posedge clk); #1;
    check("b/ip_cnt", 32'(v_ip_cnt), 32'd2);
    idle(3);
    force u_b.ip_cnt_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release u_b.ip_cnt_q;
    #1;
    check("b/ip_cnt_preload", 32'(v_ip_cnt), 32'hFFFF);
    run_frame(1'b1, 42, 1'b0, 1'b0, -1, "b_wrap", fc);
    @(posedge clk); #1;
    check("b/ip_cnt_wrap", 32'(v_ip_cnt), 32'd0);
    check("b/busy_after", 32'(v_busy), 32'd0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
